// File: rtl/fetch_unit_if.sv
// Fetch-stage bus between the processor top level and fetch_unit.
// The top level (master) supplies the PC, program size and packed ROM image;
// the fetch unit (slave) returns the registered instruction and completion flag.
interface fetch_unit_if #(
    parameter int unsigned ROM_WORDS = 256,
    parameter int unsigned XLEN      = 32
);
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         rom_size;
    logic [ROM_WORDS*32-1:0] instr_rom;
    logic [XLEN-1:0]         instruction;
    logic                    fetch_complete;

    modport master (
        output pc,
        output rom_size,
        output instr_rom,
        input  instruction,
        input  fetch_complete
    );

    modport slave (
        input  pc,
        input  rom_size,
        input  instr_rom,
        output instruction,
        output fetch_complete
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: one registered 32-bit fetch per clock from a packed ROM,
// with a sticky completion flag raised once the PC reaches the effective program size.
// Optional build macro FETCH_NOP_PAD_EN: the terminal instruction becomes the canonical
// NOP (addi x0,x0,0) instead of all-zero. Reset value is all-zero either way.
module fetch_unit #(
    parameter int unsigned ROM_WORDS = 256,
    parameter int unsigned XLEN      = 32
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);

    // Index width into the word array; kept at least 1 bit for tiny ROMs.
    localparam int unsigned AW = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1;
    localparam int unsigned CAP_BYTES = ROM_WORDS * 4;

`ifdef FETCH_NOP_PAD_EN
    localparam logic [XLEN-1:0] TERM_INSTR = XLEN'(32'h0000_0013);
`else
    localparam logic [XLEN-1:0] TERM_INSTR = '0;
`endif

    typedef enum logic {
        StFetch,
        StDone
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;

    logic [31:0]     rom_words [ROM_WORDS];
    logic [XLEN-1:0] cap_bytes;
    logic [XLEN-1:0] eff_size;
    logic [AW-1:0]   word_idx;
    logic            in_range;
    logic [XLEN-1:0] rom_word;

    // Byte offset within a word never affects the fetch (word-aligned, no trap).
    logic            unused_pc_bits;
    assign unused_pc_bits = ^bus.pc[1:0];

    // Unpack the flat ROM vector into addressable words.
    for (genvar k = 0; k < ROM_WORDS; k++) begin : g_unpack
        assign rom_words[k] = bus.instr_rom[k*32 +: 32];
    end

    assign cap_bytes = XLEN'(CAP_BYTES);
    assign word_idx  = bus.pc[AW+1:2];

    // Clamp the program size to ROM capacity and decide whether pc is still inside it.
    always_comb begin
        eff_size = (bus.rom_size < cap_bytes) ? bus.rom_size : cap_bytes;
        in_range = (bus.pc < eff_size);
        // Only consumed when in_range, which guarantees word_idx < ROM_WORDS.
        rom_word = XLEN'(rom_words[word_idx]);
    end

    // Next-state and next-instruction: fetch while in range, latch terminal value once done.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        unique case (state_q)
            StFetch: begin
                if (in_range) begin
                    instr_d = rom_word;
                end else begin
                    state_d = StDone;
                    instr_d = TERM_INSTR;
                end
            end
            StDone: begin
                // Sticky: hold terminal outputs regardless of pc until reset.
                state_d = StDone;
                instr_d = TERM_INSTR;
            end
            default: begin
                state_d = StFetch;
                instr_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous, highest-priority reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    assign bus.instruction    = instr_q;
    assign bus.fetch_complete = (state_q == StDone);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by randomized
// program sizes, ROM images and PC sequences, checked against a behavioural model.
module tb_fetch_unit;

    localparam int unsigned ROM_WORDS = 256;
    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] CAP       = ROM_WORDS * 4;

`ifdef FETCH_NOP_PAD_EN
    localparam logic [31:0] TERM = 32'h0000_0013;
`else
    localparam logic [31:0] TERM = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic reset;

    fetch_unit_if #(.ROM_WORDS(ROM_WORDS), .XLEN(XLEN)) bus ();

    fetch_unit #(.ROM_WORDS(ROM_WORDS), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: program image plus expected registered outputs.
    logic [31:0] rom [ROM_WORDS];
    logic [31:0] exp_instr;
    logic        exp_done;

    task automatic load_rom();
        for (int k = 0; k < ROM_WORDS; k++) bus.instr_rom[k*32 +: 32] = rom[k];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: apply inputs, advance the model by the fetch rules, compare after the edge.
    task automatic step(input logic rst, input logic [31:0] p, input string tag);
        logic [31:0] eff;
        reset  = rst;
        bus.pc = p;
        @(posedge clk);
        eff = (bus.rom_size < CAP) ? bus.rom_size : CAP;
        if (rst) begin
            exp_instr = 32'h0;
            exp_done  = 1'b0;
        end else if (!exp_done) begin
            if (p < eff) begin
                exp_instr = rom[p >> 2];
            end else begin
                exp_instr = TERM;
                exp_done  = 1'b1;
            end
        end
        #1;
        check({tag, ".instr"}, bus.instruction, exp_instr);
        check({tag, ".done"}, {31'b0, bus.fetch_complete}, {31'b0, exp_done});
    endtask

    initial begin
        logic [31:0] p;
        reset        = 1'b1;
        bus.pc       = '0;
        bus.rom_size = 32'd12;
        exp_instr    = '0;
        exp_done     = 1'b0;

        for (int k = 0; k < ROM_WORDS; k++) rom[k] = $urandom;
        rom[0] = 32'h0050_0093;
        rom[1] = 32'h0030_0113;
        rom[2] = 32'h0020_81B3;
        load_rom();

        // Basic program of three instructions, then completion and stickiness.
        step(1'b1, 32'd0, "reset");
        step(1'b0, 32'd0, "pc0");
        step(1'b0, 32'd4, "pc4");
        step(1'b0, 32'd8, "pc8");
        check("word2_const", bus.instruction, 32'h0020_81B3);
        step(1'b0, 32'd12, "pc12_end");
        step(1'b0, 32'd16, "sticky16");
        step(1'b0, 32'd0, "sticky0");
        step(1'b0, 32'd4, "sticky4");

        // Reset while complete, then restart.
        step(1'b1, 32'd0, "reset_done");
        step(1'b0, 32'd0, "restart0");
        check("word0_const", bus.instruction, 32'h0050_0093);

        // Misaligned pc fetches the containing word.
        step(1'b0, 32'd5, "misaligned5");
        check("word1_const", bus.instruction, 32'h0030_0113);

        // Empty program.
        bus.rom_size = 32'd0;
        step(1'b1, 32'd0, "reset_empty");
        step(1'b0, 32'd0, "empty0");

        // Size beyond capacity is clamped.
        bus.rom_size = 32'd2000;
        step(1'b1, 32'd0, "reset_big");
        step(1'b0, 32'd1020, "big1020");
        step(1'b0, 32'd1024, "big1024");

        // Partial last word still fetched.
        bus.rom_size = 32'd10;
        step(1'b1, 32'd0, "reset_partial");
        step(1'b0, 32'd8, "partial8");
        step(1'b0, 32'd12, "partial12");

        // Randomized programs and pc sequences, occasional mid-run reset.
        for (int run = 0; run < 12; run++) begin
            for (int k = 0; k < ROM_WORDS; k++) rom[k] = $urandom;
            load_rom();
            bus.rom_size = $urandom_range(0, 1100);
            step(1'b1, 32'd0, "rnd_reset");
            p = 32'd0;
            for (int c = 0; c < 60; c++) begin
                case ($urandom_range(0, 9))
                    0:       p = $urandom_range(0, 1100);
                    1:       p = $urandom;
                    default: p = p + 32'd4;
                endcase
                if ($urandom_range(0, 39) == 0) begin
                    step(1'b1, p, "rnd_midreset");
                    p = 32'd0;
                end else begin
                    step(1'b0, p, "rnd");
                end
            end
            // Drive through the end of the program to exercise completion.
            p = bus.rom_size;
            step(1'b0, p, "rnd_end");
            step(1'b0, p + 32'd4, "rnd_after");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
